// File: rtl/hs_mailbox_pkg.sv
// Shared types and helpers for the hs_mailbox_mux mailbox and its arbiter.
package hs_mailbox_pkg;

  // Output-stage occupancy: EMPTY means no word is presented, FULL means valid_o is high.
  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } out_state_e;

  // Width of a channel index.
  function automatic int CH_W(input int channels);
    return $clog2(channels);
  endfunction

endpackage

// File: rtl/hs_mailbox_mux_rr_arbiter.sv
// Combinational round-robin arbiter: scans req starting at ptr, wrapping after N-1,
// and returns a one-hot grant plus the grant index. The pointer lives in the parent.
module rr_arbiter
  import hs_mailbox_pkg::*;
#(
  parameter int N = 4
) (
  input  logic [N-1:0]         req,
  input  logic [CH_W(N)-1:0]   ptr,
  output logic [N-1:0]         gnt,
  output logic [CH_W(N)-1:0]   idx
);

  localparam int W = CH_W(N);

  logic          found_s;
  logic [W-1:0]  cand_s;

  // First requester at or after ptr (modulo N) wins.
  always_comb begin
    gnt     = {N{1'b0}};
    idx     = {W{1'b0}};
    found_s = 1'b0;
    cand_s  = ptr;
    for (int k = 0; k < N; k++) begin
      cand_s = W'((int'(ptr) + k) % N);
      if (!found_s && req[cand_s]) begin
        found_s     = 1'b1;
        gnt[cand_s] = 1'b1;
        idx         = cand_s;
      end else begin
        found_s = found_s;
      end
    end
  end

endmodule

// File: rtl/hs_mailbox_mux.sv
// Multi-channel mailbox: one holding register per producer, merged onto a single
// valid/ready stream by a round-robin arbiter. Optional sticky overrun flags are
// built when HS_MAILBOX_OVERRUN_EN is defined.
module hs_mailbox_mux
  import hs_mailbox_pkg::*;
#(
  parameter int WIDTH    = 8,
  parameter int CHANNELS = 4
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [CHANNELS*WIDTH-1:0]   data_i,
  input  logic [CHANNELS-1:0]         new_data_i,
  output logic [CHANNELS-1:0]         busy_o,
  output logic [WIDTH-1:0]            data_o,
  output logic [CH_W(CHANNELS)-1:0]   ch_o,
  output logic                        valid_o,
  input  logic                        ready_i
`ifdef HS_MAILBOX_OVERRUN_EN
  ,
  output logic [CHANNELS-1:0]         overrun_o
`endif
);

  localparam int CW = CH_W(CHANNELS);

  out_state_e            state_r;
  logic [CHANNELS-1:0]   pending_r;
  logic [WIDTH-1:0]      hold_r [CHANNELS];
  logic [WIDTH-1:0]      data_r;
  logic [CW-1:0]         ch_r;
  logic [CW-1:0]         ptr_r;

  logic [CHANNELS-1:0]   busy_s;
  logic [CHANNELS-1:0]   capture_s;
  logic [CHANNELS-1:0]   gnt_s;
  logic [CHANNELS-1:0]   clear_s;
  logic [CW-1:0]         gidx_s;
  logic [CW-1:0]         next_ptr_s;
  logic                  any_s;
  logic                  load_s;

  rr_arbiter #(.N(CHANNELS)) u_arb (
    .req (pending_r),
    .ptr (ptr_r),
    .gnt (gnt_s),
    .idx (gidx_s)
  );

  // A channel is busy while its word is held or sitting in the output stage.
  always_comb begin
    busy_s = pending_r;
    for (int c = 0; c < CHANNELS; c++) begin
      if ((state_r == FULL) && (ch_r == CW'(c))) begin
        busy_s[c] = 1'b1;
      end else begin
        busy_s[c] = pending_r[c];
      end
    end
  end

  // Pointer advances past the granted channel, wrapping to 0.
  always_comb begin
    if (gidx_s == CW'(CHANNELS - 1)) begin
      next_ptr_s = {CW{1'b0}};
    end else begin
      next_ptr_s = gidx_s + CW'(1);
    end
  end

  assign any_s     = |pending_r;
  assign load_s    = ((state_r == EMPTY) || ready_i) && any_s;
  assign capture_s = new_data_i & ~busy_s;
  assign clear_s   = load_s ? gnt_s : {CHANNELS{1'b0}};

  // Holding registers: capture on a strobe to an idle channel, release on load.
  always_ff @(posedge clk) begin
    if (rst) begin
      pending_r <= {CHANNELS{1'b0}};
      for (int c = 0; c < CHANNELS; c++) begin
        hold_r[c] <= {WIDTH{1'b0}};
      end
    end else begin
      pending_r <= (pending_r & ~clear_s) | capture_s;
      for (int c = 0; c < CHANNELS; c++) begin
        if (capture_s[c]) begin
          hold_r[c] <= data_i[c*WIDTH +: WIDTH];
        end
      end
    end
  end

  // Output stage: load the granted word when empty or on accept, else hold steady.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= EMPTY;
      data_r  <= {WIDTH{1'b0}};
      ch_r    <= {CW{1'b0}};
      ptr_r   <= {CW{1'b0}};
    end else begin
      case (state_r)
        EMPTY: begin
          if (load_s) begin
            state_r <= FULL;
            data_r  <= hold_r[gidx_s];
            ch_r    <= gidx_s;
            ptr_r   <= next_ptr_s;
          end
        end
        FULL: begin
          if (load_s) begin
            data_r <= hold_r[gidx_s];
            ch_r   <= gidx_s;
            ptr_r  <= next_ptr_s;
          end else if (ready_i) begin
            state_r <= EMPTY;
          end
        end
        default: begin
          state_r <= EMPTY;
        end
      endcase
    end
  end

  assign busy_o  = busy_s;
  assign data_o  = data_r;
  assign ch_o    = ch_r;
  assign valid_o = (state_r == FULL);

`ifdef HS_MAILBOX_OVERRUN_EN
  logic [CHANNELS-1:0] overrun_r;

  // Sticky record of strobes that arrived while their channel was busy.
  always_ff @(posedge clk) begin
    if (rst) begin
      overrun_r <= {CHANNELS{1'b0}};
    end else begin
      overrun_r <= overrun_r | (new_data_i & busy_s);
    end
  end

  assign overrun_o = overrun_r;
`endif

endmodule

// File: tb/tb_hs_mailbox_mux.sv
// Scoreboard bench for hs_mailbox_mux (WIDTH=8, CHANNELS=4). Expected output words
// are queued when stimulus is issued; a negedge monitor pops them on each accept.
module tb_hs_mailbox_mux;

  localparam int WIDTH    = 8;
  localparam int CHANNELS = 4;
  localparam int CW       = 2;

  typedef struct packed {
    logic [CW-1:0]    ch;
    logic [WIDTH-1:0] data;
  } exp_t;

  logic                       clk = 1'b0;
  logic                       rst = 1'b1;
  logic [CHANNELS*WIDTH-1:0]  data_i = '0;
  logic [CHANNELS-1:0]        new_data_i = '0;
  logic [CHANNELS-1:0]        busy_o;
  logic [WIDTH-1:0]           data_o;
  logic [CW-1:0]              ch_o;
  logic                       valid_o;
  logic                       ready_i = 1'b0;
`ifdef HS_MAILBOX_OVERRUN_EN
  logic [CHANNELS-1:0]        overrun_o;
`endif

  exp_t exp_q[$];
  int   pass_cnt  = 0;
  int   total_cnt = 0;

  hs_mailbox_mux #(.WIDTH(WIDTH), .CHANNELS(CHANNELS)) dut (
    .clk        (clk),
    .rst        (rst),
    .data_i     (data_i),
    .new_data_i (new_data_i),
    .busy_o     (busy_o),
    .data_o     (data_o),
    .ch_o       (ch_o),
    .valid_o    (valid_o),
    .ready_i    (ready_i)
`ifdef HS_MAILBOX_OVERRUN_EN
    ,
    .overrun_o  (overrun_o)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act === exp) begin
      pass_cnt++;
    end else begin
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: every accept must match the oldest expected word.
  always @(negedge clk) begin
    exp_t e;
    if (!rst && valid_o && ready_i) begin
      if (exp_q.size() == 0) begin
        total_cnt++;
        $display("FAIL unexpected_word: got ch %0d data 0x%0h expected none at %0t",
                 ch_o, data_o, $time);
      end else begin
        e = exp_q.pop_front();
        chk("out_data", {24'h0, data_o}, {24'h0, e.data});
        chk("out_ch", {30'h0, ch_o}, {30'h0, e.ch});
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_strb(input int c, input logic [WIDTH-1:0] d);
    new_data_i[c] = 1'b1;
    data_i[c*WIDTH +: WIDTH] = d;
  endtask

  task automatic clr_strb();
    new_data_i = '0;
  endtask

  task automatic push(input int c, input logic [WIDTH-1:0] d);
    exp_t e;
    e.ch   = CW'(c);
    e.data = d;
    exp_q.push_back(e);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    clr_strb();
    tick();
    rst = 1'b0;
  endtask

  task automatic drain(input int budget);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < budget) begin
      tick();
      n++;
    end
    tick();
    chk("drain_left", exp_q.size(), 32'd0);
  endtask

  initial begin
    tick();
    tick();
    rst = 1'b0;

    // Reset state
    chk("rst_valid", valid_o, 1'b0);
    chk("rst_busy", busy_o, 4'b0000);
    chk("rst_data", data_o, 8'h00);
    chk("rst_ch", ch_o, 2'd0);
`ifdef HS_MAILBOX_OVERRUN_EN
    chk("rst_overrun", overrun_o, 4'b0000);
`endif

    // Single transfer on ch2
    ready_i = 1'b1;
    set_strb(2, 8'hA5);
    push(2, 8'hA5);
    tick();
    clr_strb();
    chk("t1_busy_cap", busy_o, 4'b0100);
    chk("t1_valid_early", valid_o, 1'b0);
    tick();
    chk("t1_valid", valid_o, 1'b1);
    chk("t1_busy_stage", busy_o, 4'b0100);
    tick();
    chk("t1_busy_done", busy_o, 4'b0000);
    chk("t1_valid_done", valid_o, 1'b0);

    // Simultaneous strobes, then wrap-around to ch0
    do_reset();
    ready_i = 1'b1;
    for (int c = 0; c < CHANNELS; c++) begin
      set_strb(c, 8'(8'h10 + c));
      push(c, 8'(8'h10 + c));
    end
    tick();
    clr_strb();
    chk("t2_busy_all", busy_o, 4'b1111);
    tick();
    chk("t2_ch0", ch_o, 2'd0);
    tick();
    chk("t2_ch1", ch_o, 2'd1);
    tick();
    chk("t2_ch2", ch_o, 2'd2);
    set_strb(0, 8'h20);
    set_strb(1, 8'h21);
    push(0, 8'h20);
    push(1, 8'h21);
    tick();
    clr_strb();
    chk("t2_ch3", ch_o, 2'd3);
    chk("t2_busy_wrap", busy_o, 4'b1011);
    tick();
    chk("t2_wrap_ch", ch_o, 2'd0);
    chk("t2_wrap_data", data_o, 8'h20);
    drain(10);

    // Backpressure with ch1 in the stage and ch3 pending
    do_reset();
    ready_i = 1'b0;
    set_strb(1, 8'h3C);
    set_strb(3, 8'h5A);
    push(1, 8'h3C);
    push(3, 8'h5A);
    tick();
    clr_strb();
    tick();
    for (int i = 0; i < 5; i++) begin
      chk("t3_valid", valid_o, 1'b1);
      chk("t3_data", data_o, 8'h3C);
      chk("t3_ch", ch_o, 2'd1);
      chk("t3_busy", busy_o, 4'b1010);
      tick();
    end
    ready_i = 1'b1;
    tick();
    chk("t3_next_ch", ch_o, 2'd3);
    chk("t3_next_data", data_o, 8'h5A);
    drain(10);

    // Strobe in the accept cycle is dropped; one cycle later it is captured
    ready_i = 1'b1;
    set_strb(1, 8'h44);
    push(1, 8'h44);
    tick();
    clr_strb();
    tick();
    set_strb(1, 8'h55);
    tick();
    clr_strb();
    chk("t4_drop_busy", busy_o, 4'b0000);
    chk("t4_drop_valid", valid_o, 1'b0);
    set_strb(1, 8'h66);
    push(1, 8'h66);
    tick();
    clr_strb();
    chk("t4_recap_busy", busy_o, 4'b0010);
    drain(10);
`ifdef HS_MAILBOX_OVERRUN_EN
    chk("t4_overrun", overrun_o, 4'b0010);

    // Overrun flag on ch0
    do_reset();
    chk("t5_overrun_clr", overrun_o, 4'b0000);
    ready_i = 1'b0;
    set_strb(0, 8'h01);
    push(0, 8'h01);
    tick();
    set_strb(0, 8'h02);
    tick();
    clr_strb();
    chk("t5_overrun_set", overrun_o, 4'b0001);
    ready_i = 1'b1;
    drain(10);
    tick();
    tick();
    chk("t5_overrun_sticky", overrun_o, 4'b0001);
`endif

    // Reset mid-operation
    ready_i = 1'b0;
    set_strb(0, 8'hA0);
    set_strb(1, 8'hA1);
    set_strb(2, 8'hA2);
    tick();
    clr_strb();
    tick();
    chk("t6_pre_valid", valid_o, 1'b1);
    chk("t6_pre_busy", busy_o, 4'b0111);
    rst = 1'b1;
    set_strb(2, 8'hEE);
    tick();
    clr_strb();
    rst = 1'b0;
    chk("t6_rst_valid", valid_o, 1'b0);
    chk("t6_rst_busy", busy_o, 4'b0000);
`ifdef HS_MAILBOX_OVERRUN_EN
    chk("t6_rst_overrun", overrun_o, 4'b0000);
`endif
    ready_i = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
    end
    chk("t6_no_stale", valid_o, 1'b0);
    set_strb(3, 8'h77);
    push(3, 8'h77);
    tick();
    clr_strb();
    tick();
    chk("t6_new_valid", valid_o, 1'b1);
    chk("t6_new_ch", ch_o, 2'd3);
    drain(10);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
